// File: rtl/lcd_pkg.sv
// Shared types and constants for the character LCD scheduler.
package lcd_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StActive,
      StRecover
   } lcd_state_e;

   localparam logic [7:0] SPACE_CHAR = 8'h20;

   localparam int unsigned DEFAULT_COLS     = 16;
   localparam int unsigned DEFAULT_LINE_LEN = 40;

endpackage

// File: rtl/lcd_char_fifo.sv
// Synchronous character FIFO with synchronous clear and async active-low reset.
// Callers must not push when full; pops on empty are ignored.
module lcd_char_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FullCnt);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~clr;
   assign do_pop  = pop & ~empty & ~clr;
   assign rdata   = mem_q[rd_ptr_q];

   // Storage array; no reset needed since contents are qualified by count_q
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/lcd_char_scheduler.sv
// Front end for the character LCD driver: round-robin arbitration of two requesters into
// a FIFO, one-at-a-time issue over the WRITE/WAITING/WRITING handshake, cursor tracking.
// Optional feature: define LCD_COL_WRAP_EN to pad each line with spaces from COLS up to
// LINE_LEN so the next character lands at the start of the other line.
module lcd_char_scheduler
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned COLS     = DEFAULT_COLS,
   parameter int unsigned LINE_LEN = DEFAULT_LINE_LEN,
   parameter int unsigned TIMEOUT  = 16384
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        FLUSH,
   input  logic                        A_VALID,
   input  logic [7:0]                  A_CHAR,
   output logic                        A_READY,
   input  logic                        B_VALID,
   input  logic [7:0]                  B_CHAR,
   output logic                        B_READY,
   input  logic                        LCD_EN_IN,
   input  logic                        LCD_WAITING,
   input  logic                        LCD_WRITING,
   output logic                        LCD_WRITE,
   output logic [7:0]                  LCD_CHAR,
   output logic [$clog2(LINE_LEN)-1:0] COL,
   output logic                        LINE,
   output logic                        BUSY,
   output logic                        ERR
);

   localparam int unsigned CW = $clog2(LINE_LEN);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned PW = $clog2(LINE_LEN - COLS + 1);

   localparam logic [CW:0]   LineLenW = (CW+1)'(LINE_LEN);
   localparam logic [CW:0]   ColsW    = (CW+1)'(COLS);
   localparam logic [TW-1:0] TimeoutW = TW'(TIMEOUT);
   localparam logic [PW-1:0] PadInit  = PW'(LINE_LEN - COLS);

`ifdef LCD_COL_WRAP_EN
   localparam bit PadOnWrap = 1'b1;
`else
   localparam bit PadOnWrap = 1'b0;
`endif

   lcd_state_e     state_q, state_d;
   logic [7:0]     char_q, char_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           err_q, err_d;
   logic [CW-1:0]  col_q, col_d;
   logic           line_q, line_d;
   logic [PW-1:0]  pad_q, pad_d;
   logic           last_b_q;

   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_push;
   logic           fifo_pop;
   logic [7:0]     fifo_rdata;
   logic [7:0]     push_char;
   logic           arb_ok;
   logic           grant_a;
   logic           grant_b;
   logic           drv_ready;
   logic           pad_pending;
   logic           load_pad;
   logic           write_done;
   logic [CW:0]    col_inc;

   lcd_char_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (FLUSH),
      .push  (fifo_push),
      .wdata (push_char),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Round-robin grant: on a tie the side that did not win last time goes first.
   // Full is the pre-pop occupancy, so a same-cycle pop never frees a slot early.
   always_comb begin
      arb_ok    = ~fifo_full & ~FLUSH;
      grant_a   = arb_ok & A_VALID & (~B_VALID | last_b_q);
      grant_b   = arb_ok & B_VALID & (~A_VALID | ~last_b_q);
      fifo_push = grant_a | grant_b;
      push_char = grant_a ? A_CHAR : B_CHAR;
      A_READY   = grant_a;
      B_READY   = grant_b;
   end

   // Last-winner pointer; starts at B so A takes the first tie
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_b_q <= 1'b1;
      end else if (grant_a) begin
         last_b_q <= 1'b0;
      end else if (grant_b) begin
         last_b_q <= 1'b1;
      end
   end

   // WAITING and WRITING together means the driver is shutting down
   assign drv_ready   = LCD_WAITING & ~LCD_WRITING & LCD_EN_IN;
   assign pad_pending = (pad_q != '0);

   // Handshake FSM next-state, character load and timeout
   always_comb begin
      state_d    = state_q;
      char_d     = char_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      fifo_pop   = 1'b0;
      load_pad   = 1'b0;
      write_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            // No new load during FLUSH so a flushed character is never issued
            if (drv_ready && !FLUSH && (pad_pending || !fifo_empty)) begin
               state_d = StIssue;
               tmo_d   = '0;
               if (pad_pending) begin
                  char_d   = SPACE_CHAR;
                  load_pad = 1'b1;
               end else begin
                  char_d   = fifo_rdata;
                  fifo_pop = 1'b1;
               end
            end
         end
         StIssue: begin
            if (LCD_WRITING) begin
               state_d = StActive;
            end else if (tmo_q + TW'(1) == TimeoutW) begin
               // Driver never accepted: drop the character without moving the cursor
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StActive: begin
            if (!LCD_WRITING) begin
               state_d    = StRecover;
               write_done = 1'b1;
            end
         end
         StRecover: begin
            if (LCD_WAITING) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Cursor advance on each completed write, plus end-of-visible-line padding
   always_comb begin
      col_d   = col_q;
      line_d  = line_q;
      pad_d   = pad_q;
      col_inc = {1'b0, col_q} + (CW+1)'(1);
      if (FLUSH) begin
         col_d  = '0;
         line_d = 1'b0;
         pad_d  = '0;
      end else begin
         if (load_pad) begin
            pad_d = pad_q - PW'(1);
         end
         if (write_done) begin
            if (col_inc == LineLenW) begin
               col_d  = '0;
               line_d = ~line_q;
            end else begin
               col_d = col_inc[CW-1:0];
            end
            if (PadOnWrap && (col_inc == ColsW)) begin
               pad_d = PadInit;
            end
         end
      end
   end

   // State, character, timeout, error and cursor registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         char_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         col_q   <= '0;
         line_q  <= 1'b0;
         pad_q   <= '0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         col_q   <= col_d;
         line_q  <= line_d;
         pad_q   <= pad_d;
      end
   end

   assign LCD_WRITE = (state_q == StIssue);
   assign LCD_CHAR  = char_q;
   assign COL       = col_q;
   assign LINE      = line_q;
   assign BUSY      = (state_q != StIdle) | ~fifo_empty;
   assign ERR       = err_q;

endmodule
